// File: rtl/rv32i_types.sv
// Shared RV32I decode types used by the front end and the instruction queue.
// INST_Q_DEPTH is the default bundle depth of instruction_queue.
package rv32i_types;

    localparam int INST_Q_DEPTH = 8;

    // One decoded instruction as handed from decode to rename/dispatch
    typedef struct packed {
        logic        valid;
        logic [31:0] pc_curr;
        logic [31:0] pc_next;
        logic [31:0] inst;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [4:0]  rd_addr;
    } instruction_info_reg_t;

endpackage

// File: rtl/inst_q_mem.sv
// Bundle storage for instruction_queue: DEPTH x SS records, one write port and
// one synchronous read port whose output register can be cleared.
module inst_q_mem
    import rv32i_types::*;
#(
    parameter int SS    = 2,
    parameter int DEPTH = INST_Q_DEPTH
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic [$clog2(DEPTH)-1:0]            waddr,
    input  instruction_info_reg_t [SS-1:0]      wdata,
    input  logic                                re,
    input  logic [$clog2(DEPTH)-1:0]            raddr,
    input  logic                                clr,
    output instruction_info_reg_t [SS-1:0]      rdata
);

    typedef instruction_info_reg_t [SS-1:0] bundle_t;

    bundle_t mem [DEPTH];

    // Array write; contents are intentionally not reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered head read; clear wins so reset/flush leave every valid bit low
    always_ff @(posedge clk) begin
        if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instruction_queue.sv
// Bundle-wide circular FIFO between decode and rename_dispatch.
// Optional feature macro: INST_Q_FLUSH_EN adds a flush input that empties the
// queue and clears the registered output bundle.
module instruction_queue
    import rv32i_types::*;
#(
    parameter int SS    = 2,
    parameter int DEPTH = INST_Q_DEPTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                push,
    input  instruction_info_reg_t [SS-1:0]      in_bundle,
    output logic                                full,
    input  logic                                pop,
    output logic                                empty,
    output instruction_info_reg_t [SS-1:0]      out_bundle,
`ifdef INST_Q_FLUSH_EN
    output logic [$clog2(DEPTH):0]              count,
    input  logic                                flush
`else
    output logic [$clog2(DEPTH):0]              count
`endif
);

    localparam int AW = $clog2(DEPTH);

    // MSB of each pointer is the wrap bit; the rest index the storage
    logic [AW:0] head;
    logic [AW:0] tail;
    logic        flush_i;
    logic        clr;
    logic        push_acc;
    logic        pop_acc;

`ifdef INST_Q_FLUSH_EN
    assign flush_i = flush;
`else
    assign flush_i = 1'b0;
`endif

    // Flags come only from pointer registers, so pop never reaches full combinationally
    assign empty = (head == tail);
    assign full  = (head[AW-1:0] == tail[AW-1:0]) && (head[AW] != tail[AW]);
    assign count = tail - head;

    // Reset and flush dominate any same-cycle push or pop
    assign clr      = rst || flush_i;
    assign push_acc = push && !full  && !clr;
    assign pop_acc  = pop  && !empty && !clr;

    // Pointer update; natural binary overflow gives the index roll and wrap toggle
    always_ff @(posedge clk) begin
        if (clr) begin
            head <= '0;
            tail <= '0;
        end else begin
            if (push_acc) begin
                tail <= tail + 1'b1;
            end
            if (pop_acc) begin
                head <= head + 1'b1;
            end
        end
    end

    // With count==1 the read hits the old head slot; the write goes to a different slot
    inst_q_mem #(
        .SS    (SS),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk),
        .we    (push_acc),
        .waddr (tail[AW-1:0]),
        .wdata (in_bundle),
        .re    (pop_acc),
        .raddr (head[AW-1:0]),
        .clr   (clr),
        .rdata (out_bundle)
    );

endmodule

// File: tb/tb_instruction_queue.sv
// Self-checking bench for instruction_queue (SS=2, DEPTH=8).
// Stimulus queues expected results; a negedge monitor drains and compares them.
module tb_instruction_queue;
    import rv32i_types::*;

    localparam int SS    = 2;
    localparam int DEPTH = 8;

    typedef instruction_info_reg_t [SS-1:0] bundle_t;

    typedef struct {
        string   name;
        int      kind;   // 0 count, 1 empty, 2 full, 3 out_bundle
        int      ei;
        bundle_t eb;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        push = 1'b0;
    logic        pop = 1'b0;
    logic        flush = 1'b0;
    bundle_t     in_bundle = '0;
    logic        full;
    logic        empty;
    bundle_t     out_bundle;
    logic [3:0]  count;

    exp_t exp_q [$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   step  = 0;

    instruction_queue #(
        .SS    (SS),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .in_bundle  (in_bundle),
        .full       (full),
        .pop        (pop),
        .empty      (empty),
        .out_bundle (out_bundle),
`ifdef INST_Q_FLUSH_EN
        .count      (count),
        .flush      (flush)
`else
        .count      (count)
`endif
    );

    always #5 clk = ~clk;

    // Bundle tagged by pc: slot i holds pc+4*i
    function automatic bundle_t mk_bundle(input logic [31:0] pc);
        bundle_t b;
        for (int i = 0; i < SS; i++) begin
            b[i].valid    = 1'b1;
            b[i].pc_curr  = pc + 32'(4 * i);
            b[i].pc_next  = pc + 32'(4 * i + 4);
            b[i].inst     = {pc[15:0], 16'h0013} ^ 32'(i);
            b[i].rs1_addr = pc[7:3];
            b[i].rs2_addr = pc[8:4] ^ 5'(i);
            b[i].rd_addr  = pc[9:5] + 5'(i);
        end
        return b;
    endfunction

    function automatic void expect_int(input string nm, input int kind, input int v);
        exp_t e;
        e.name = nm; e.kind = kind; e.ei = v; e.eb = '0;
        exp_q.push_back(e);
    endfunction

    // One clock: drive inputs, take the edge, queue the hand-computed expectations
    task automatic cyc(input bit r, input bit p, input logic [31:0] ppc, input bit q,
                       input bit f, input int e_cnt, input bit e_empty, input bit e_full,
                       input logic [31:0] e_pc, input bit e_vld);
        exp_t e;
        rst  = r;
        push = p;
        in_bundle = p ? mk_bundle(ppc) : bundle_t'('0);
        pop  = q;
        flush = f;
        @(posedge clk);
        #1;
        step++;
        expect_int($sformatf("count@%0d", step), 0, e_cnt);
        expect_int($sformatf("empty@%0d", step), 1, int'(e_empty));
        expect_int($sformatf("full@%0d", step), 2, int'(e_full));
        e.name = $sformatf("out_bundle@%0d", step);
        e.kind = 3;
        e.ei   = 0;
        e.eb   = e_vld ? mk_bundle(e_pc) : bundle_t'('0);
        exp_q.push_back(e);
        rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0;
    endtask

    // Monitor: compare everything queued since the last falling edge
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            case (e.kind)
                0: if (int'(count) != e.ei) begin
                       n_bad++;
                       $display("FAIL %s: got %0d want %0d", e.name, count, e.ei);
                   end
                1: if (int'(empty) != e.ei) begin
                       n_bad++;
                       $display("FAIL %s: got %0d want %0d", e.name, empty, e.ei);
                   end
                2: if (int'(full) != e.ei) begin
                       n_bad++;
                       $display("FAIL %s: got %0d want %0d", e.name, full, e.ei);
                   end
                default: if (out_bundle !== e.eb) begin
                       n_bad++;
                       $display("FAIL %s: got v%0d pc %h/%h want v%0d pc %h/%h", e.name,
                                out_bundle[0].valid, out_bundle[0].pc_curr, out_bundle[1].pc_curr,
                                e.eb[0].valid, e.eb[0].pc_curr, e.eb[1].pc_curr);
                   end
            endcase
        end
    end

    initial begin
        // Reset held for two cycles with push/pop active: both must be ignored
        cyc(1, 1, 32'hDEAD0000, 1, 0, 0, 1, 0, 32'h0, 0);
        cyc(1, 1, 32'hDEAD0008, 1, 0, 0, 1, 0, 32'h0, 0);
        // Idle, then pop with nothing stored
        cyc(0, 0, 32'h0, 0, 0, 0, 1, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 1, 0, 0, 1, 0, 32'h0, 0);
        // Fill A..H
        for (int i = 0; i < 8; i++)
            cyc(0, 1, 32'h1000 + 32'(8 * i), 0, 0, i + 1, 0, (i == 7), 32'h0, 0);
        // Push I while full: dropped
        cyc(0, 1, 32'h1040, 0, 0, 8, 0, 1, 32'h0, 0);
        // Push I and pop together while full: A out, I dropped, count 7
        cyc(0, 1, 32'h1040, 1, 0, 7, 0, 0, 32'h1000, 1);
        // Remaining pops return B..H in order
        for (int i = 1; i < 8; i++)
            cyc(0, 0, 32'h0, 1, 0, 7 - i, (i == 7), 0, 32'h1000 + 32'(8 * i), 1);
        // Pop while empty: out_bundle held at H
        cyc(0, 0, 32'h0, 1, 0, 0, 1, 0, 32'h1038, 1);
        // count==1 push+pop: no bypass
        cyc(0, 1, 32'h2000, 0, 0, 1, 0, 0, 32'h1038, 1);
        cyc(0, 1, 32'h2008, 1, 0, 1, 0, 0, 32'h2000, 1);
        cyc(0, 0, 32'h0, 1, 0, 0, 1, 0, 32'h2008, 1);
        // Preload 3, then stream 20 with push+pop every cycle
        for (int i = 0; i < 3; i++)
            cyc(0, 1, 32'h3000 + 32'(8 * i), 0, 0, i + 1, 0, 0, 32'h2008, 1);
        for (int i = 0; i < 20; i++)
            cyc(0, 1, 32'h3018 + 32'(8 * i), 1, 0, 3, 0, 0, 32'h3000 + 32'(8 * i), 1);
        for (int i = 0; i < 3; i++)
            cyc(0, 0, 32'h0, 1, 0, 2 - i, (i == 2), 0, 32'h30A0 + 32'(8 * i), 1);
`ifdef INST_Q_FLUSH_EN
        // Flush with count 5 beats same-cycle push and pop
        for (int i = 0; i < 5; i++)
            cyc(0, 1, 32'h4000 + 32'(8 * i), 0, 0, i + 1, 0, 0, 32'h30B0, 1);
        cyc(0, 1, 32'h5000, 1, 1, 0, 1, 0, 32'h0, 0);
        cyc(0, 1, 32'h6000, 0, 0, 1, 0, 0, 32'h0, 0);
        cyc(0, 0, 32'h0, 1, 0, 0, 1, 0, 32'h6000, 1);
`endif
        @(negedge clk);
        @(negedge clk);
        if (exp_q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded limit, want completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/instruction_queue.md
# instruction_queue

Bundle-wide circular FIFO between fetch/decode and `rename_dispatch`. Each entry holds one SS-wide bundle of decoded `instruction_info_reg_t` records. Decode pushes whole bundles; `rename_dispatch` pops whole bundles via `pop_inst_q`. Read data is registered, so it is valid the cycle after a pop, which matches `rename_dispatch`'s `avail_inst` delay.

## Interface
- SS, 2, instructions per bundle (superscalar width)
- DEPTH, 8, bundle entries; power of two, ≥2
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- push  in  1  write `in_bundle` at tail this cycle
- in_bundle  in  SS × instruction_info_reg_t  bundle from decode
- full  out  1  no free entry; registered-state derived
- pop  in  1  driven by `pop_inst_q` of `rename_dispatch`
- empty  out  1  no valid entry; drives `inst_q_empty`
- out_bundle  out  SS × instruction_info_reg_t  registered head bundle; drives `instruction`
- count  out  $clog2(DEPTH)+1  occupied bundles
- flush  in  1  present only with `INST_Q_FLUSH_EN`; discard all contents

## Operation
- Pointers `head` and `tail`, each $clog2(DEPTH)+1 bits. The MSB is the wrap bit.
- empty = (head == tail).
- full = index bits equal and wrap bits differ.
- count = tail − head, modulo 2^($clog2(DEPTH)+1).
- Accepted push: `push && !full`. Writes the bundle to `mem[tail idx]` and increments tail.
- Accepted pop: `pop && !empty`. Loads `out_bundle <= mem[head idx]` and increments head.
- Push while full is ignored, even if a pop is accepted in the same cycle. `full` never depends on `pop` (no comb path pop→full).
- Pop while empty is ignored. `out_bundle` is held unchanged.
- Simultaneous accepted push and pop:
  - both pointers advance and count is unchanged;
  - with count==1 the pop reads the old head, never the incoming bundle (no bypass).
- `out_bundle` holds its value until the next accepted pop.
- Pointer wrap: index `DEPTH-1` rolls to 0 and the wrap bit toggles.
- Reset:
  - head = tail = 0; empty=1, full=0, count=0;
  - every `out_bundle[i]` is zeroed (`valid`=0);
  - memory contents are not reset.
- Reset during traffic: `rst` overrides push, pop and flush in that cycle.

## Timing
- Push accepted at edge N:
  - empty falls and count increments, visible after edge N;
  - earliest pop is in cycle N+1.
- Pop accepted at edge M: `out_bundle` is valid after edge M, which is the cycle `rename_dispatch` sees `avail_inst`=1.
- Back-to-back pops every cycle are supported; sustained throughput is 1 bundle/cycle in and out.
- All outputs are registered or derived only from pointer registers.

## Configuration
- `INST_Q_FLUSH_EN` defined:
  - `flush` port exists;
  - flush at an edge sets head = tail = 0 and zeroes every `out_bundle[i]`;
  - flush beats a same-cycle push and pop, so neither is accepted;
  - empty=1 from the next cycle.
- Undefined: no `flush` port; behaviour equals flush tied to 0.

## Structure
- `rv32i_types` keeps `instruction_info_reg_t`. Add the constant `INST_Q_DEPTH` (8) there as the parameter default source.
- The pointer/flag logic stays in this module.
- Storage goes in one sub-module `inst_q_mem`: DEPTH × SS entries, one write port, one synchronous read port with an output register that has a clear input.

## Test plan
- Reset, then idle → empty=1, full=0, count=0, `out_bundle[*].valid`=0. Pop with no push → `out_bundle` unchanged, count=0.
- Push bundles A..H (pc_curr 0x1000 stepping 0x8), then push I → count=8, full=1, I dropped. Eight pops → `out_bundle` pc_curr = 0x1000..0x1038 in order, one per cycle after each pop, then empty=1.
- With count==8, push I and pop together → pop returns A, I dropped, count=7.
- With count==1 (A), push B and pop together → `out_bundle`=A, count=1, next pop returns B.
- Stream 20 bundles with push and pop every cycle from count=3 → in-order output, count stays 3, pointers wrap twice.
- `INST_Q_FLUSH_EN` on:
  - with count=5, assert flush+push+pop → next cycle count=0, empty=1, `out_bundle` valid=0;
  - a subsequent push of X then pop → X.
